// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state encoding and board delay defaults for the reset sequencer
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_CPU_DLY  = 2'd2,
        ST_RUN      = 2'd3
    } seq_state_e;

    // Defaults for the 9K board (small PSRAM, quick init)
    localparam int BOARD_9K_SYNC_STAGES  = 2;
    localparam int BOARD_9K_PERIPH_DELAY = 16;
    localparam int BOARD_9K_MEM_TIMEOUT  = 65535;
    localparam int BOARD_9K_CPU_DELAY    = 8;
    localparam int BOARD_9K_CNT_W        = 16;

    // Defaults for the 20K board (SDRAM needs a longer power-up init)
    localparam int BOARD_20K_SYNC_STAGES  = 3;
    localparam int BOARD_20K_PERIPH_DELAY = 32;
    localparam int BOARD_20K_MEM_TIMEOUT  = 65535;
    localparam int BOARD_20K_CPU_DELAY    = 16;
    localparam int BOARD_20K_CNT_W        = 16;

endpackage

// File: rtl/reset_sequencer_sync.sv
// rtl/reset_sequencer_sync.sv - async-assert, sync-deassert reset synchroniser, reusable per clock domain
module reset_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic sync_reset_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_reset_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged release of peripheral, memory and core resets with soft-reset restart
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int PERIPH_DELAY = 16,
    parameter int MEM_TIMEOUT  = 65535,
    parameter int CPU_DELAY    = 8,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mem_init_done,
    input  logic soft_reset_req,
    output logic periph_reset_n,
    output logic mem_reset_n,
    output logic cpu_reset_n,
    output logic sys_ready,
    output logic mem_timeout
);

    localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [CNT_W-1:0] MEM_LAST    = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             rst_int_n;
    seq_state_e       state;
    seq_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             periph_nxt;
    logic             mem_nxt;
    logic             cpu_nxt;
    logic             ready_nxt;
    logic             timeout_nxt;

    reset_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .sync_reset_n (rst_int_n)
    );

    // rst_int_n clears asynchronously, so every output drops in the same instant reset_n falls
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state          <= ST_HOLD;
            cnt            <= '0;
            periph_reset_n <= 1'b0;
            mem_reset_n    <= 1'b0;
            cpu_reset_n    <= 1'b0;
            sys_ready      <= 1'b0;
            mem_timeout    <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            periph_reset_n <= periph_nxt;
            mem_reset_n    <= mem_nxt;
            cpu_reset_n    <= cpu_nxt;
            sys_ready      <= ready_nxt;
            mem_timeout    <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        periph_nxt  = periph_reset_n;
        mem_nxt     = mem_reset_n;
        cpu_nxt     = cpu_reset_n;
        ready_nxt   = sys_ready;
        timeout_nxt = mem_timeout;

        // mem_timeout survives a soft restart so software can still read why the last boot was slow
        if (soft_reset_req && (state != ST_HOLD)) begin
            state_nxt  = ST_HOLD;
            cnt_nxt    = '0;
            periph_nxt = 1'b0;
            mem_nxt    = 1'b0;
            cpu_nxt    = 1'b0;
            ready_nxt  = 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == PERIPH_LAST) begin
                        periph_nxt = 1'b1;
                        mem_nxt    = 1'b1;
                        cnt_nxt    = '0;
                        state_nxt  = ST_MEM_WAIT;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_MEM_WAIT: begin
                    // init done beats a timeout landing on the same cycle
                    if (mem_init_done) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_CPU_DLY;
                    end else if (cnt == MEM_LAST) begin
                        timeout_nxt = 1'b1;
                        cnt_nxt     = '0;
                        state_nxt   = ST_CPU_DLY;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_CPU_DLY: begin
                    if (cnt == CPU_LAST) begin
                        cpu_nxt   = 1'b1;
                        ready_nxt = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_RUN;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized self-checking bench for reset_sequencer
module tb_reset_sequencer;

    localparam int SS = 2;
    localparam int PD = 16;
    localparam int MT = 1000;
    localparam int CD = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic mem_init_done;
    logic soft_reset_req;
    logic periph_reset_n;
    logic mem_reset_n;
    logic cpu_reset_n;
    logic sys_ready;
    logic mem_timeout;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rise_p = -1;
    int rise_m = -1;
    int rise_c = -1;
    int rise_s = -1;
    int rise_t = -1;
    logic pv_p = 1'b0;
    logic pv_m = 1'b0;
    logic pv_c = 1'b0;
    logic pv_s = 1'b0;
    logic pv_t = 1'b0;
    bit exp_to = 1'b0;
    int base;
    int d;

    reset_sequencer #(
        .SYNC_STAGES  (SS),
        .PERIPH_DELAY (PD),
        .MEM_TIMEOUT  (MT),
        .CPU_DELAY    (CD),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_init_done  (mem_init_done),
        .soft_reset_req (soft_reset_req),
        .periph_reset_n (periph_reset_n),
        .mem_reset_n    (mem_reset_n),
        .cpu_reset_n    (cpu_reset_n),
        .sys_ready      (sys_ready),
        .mem_timeout    (mem_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the edge number at which each output was first seen high
    always @(posedge clk) begin
        #1;
        if (periph_reset_n && !pv_p) rise_p = cyc;
        if (mem_reset_n && !pv_m) rise_m = cyc;
        if (cpu_reset_n && !pv_c) rise_c = cyc;
        if (sys_ready && !pv_s) rise_s = cyc;
        if (mem_timeout && !pv_t) rise_t = cyc;
        pv_p = periph_reset_n;
        pv_m = mem_reset_n;
        pv_c = cpu_reset_n;
        pv_s = sys_ready;
        pv_t = mem_timeout;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // base_p: edge at which periph/mem are expected to release; d: cycles after that
    // edge when mem_init_done is raised (negative = never); tied: done already high.
    task automatic run_seq(input int base_p, input int d_in, input bit tied, input bit hold_pulse);
        int s_edge;
        int c_edge;
        int mem_low;
        bit to_hit;
        to_hit = !tied && ((d_in < 0) || (d_in >= MT));
        s_edge = to_hit ? base_p + MT : (tied ? base_p + 1 : base_p + d_in + 1);
        c_edge = s_edge + CD;
        rise_p = -1;
        rise_m = -1;
        rise_c = -1;
        rise_s = -1;
        rise_t = -1;
        mem_low = 0;
        mem_init_done = tied;
        while (cyc < c_edge + 2) begin
            @(negedge clk);
            if (!tied && d_in >= 0 && cyc == base_p + d_in) mem_init_done = 1'b1;
            if (hold_pulse) soft_reset_req = (cyc == base_p - 8);
            if (cyc > base_p && cyc <= c_edge && !mem_reset_n) mem_low++;
        end
        soft_reset_req = 1'b0;
        check("periph_rise", rise_p, base_p);
        check("mem_rise", rise_m, base_p);
        check("cpu_rise", rise_c, c_edge);
        check("ready_rise", rise_s, c_edge);
        check("mem_held_low_cycles", mem_low, 0);
        check("timeout_rise", rise_t, (to_hit && !exp_to) ? base_p + MT : -1);
        exp_to = exp_to | to_hit;
        check("timeout_flag", int'(mem_timeout), int'(exp_to));
    endtask

    task automatic soft_restart(output int base_p);
        soft_reset_req = 1'b1;
        @(negedge clk);
        soft_reset_req = 1'b0;
        check("soft_periph", int'(periph_reset_n), 0);
        check("soft_mem", int'(mem_reset_n), 0);
        check("soft_cpu", int'(cpu_reset_n), 0);
        check("soft_ready", int'(sys_ready), 0);
        check("soft_timeout_kept", int'(mem_timeout), int'(exp_to));
        base_p = cyc + PD;
    endtask

    initial begin
        reset_n = 1'b1;
        mem_init_done = 1'b1;
        soft_reset_req = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_periph", int'(periph_reset_n), 0);
        check("reset_mem", int'(mem_reset_n), 0);
        check("reset_cpu", int'(cpu_reset_n), 0);
        check("reset_ready", int'(sys_ready), 0);
        check("reset_timeout", int'(mem_timeout), 0);

        reset_n = 1'b1;
        run_seq(cyc + SS + PD, 0, 1'b1, 1'b0);

        soft_restart(base);
        run_seq(base, 100, 1'b0, 1'b1);

        soft_restart(base);
        run_seq(base, MT - 1, 1'b0, 1'b0);

        soft_restart(base);
        run_seq(base, -1, 1'b0, 1'b0);

        soft_restart(base);
        mem_init_done = 1'b1;
        while (cyc < base + 4) @(negedge clk);
        check("glitch_pre_cpu", int'(cpu_reset_n), 0);
        check("glitch_pre_periph", int'(periph_reset_n), 1);
        #2 reset_n = 1'b0;
        #1;
        check("glitch_periph", int'(periph_reset_n), 0);
        check("glitch_mem", int'(mem_reset_n), 0);
        check("glitch_cpu", int'(cpu_reset_n), 0);
        check("glitch_ready", int'(sys_ready), 0);
        check("glitch_timeout", int'(mem_timeout), 0);
        exp_to = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_seq(cyc + SS + PD, 0, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            soft_restart(base);
            if ($urandom_range(0, 5) == 0) d = -1;
            else d = int'($urandom_range(0, 1050));
            run_seq(base, d, 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
